// File: rtl/mp3_pkg.sv
// Shared state encoding, sizing constants and byte-lane helper for the MP3 ROM streamer.
package mp3_pkg;

    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned ADDR_W         = 21;
    localparam int unsigned WORD_W         = 32;
    localparam int unsigned IDX_W          = $clog2(BYTES_PER_WORD);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_DREQ = 3'd1,
        FETCH     = 3'd2,
        LOAD      = 3'd3,
        SEND      = 3'd4,
        DONE      = 3'd5
    } state_e;

    // Byte lane of a ROM word; lane 0 is the most significant byte.
    function automatic logic [7:0] byte_sel(input logic [WORD_W-1:0] word,
                                            input logic [IDX_W-1:0]  idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = word[31:24];
            2'd1:    b = word[23:16];
            2'd2:    b = word[15:8];
            default: b = word[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/dreq_sync.sv
// Two-flop synchroniser bringing the decoder's DREQ into the mp3_clk domain.
module dreq_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic async_i,
    output logic sync_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
        end
    end

    assign sync_o = sync_q;

endmodule

// File: rtl/mp3_rom_streamer.sv
// Streams 32-bit ROM words MSB-byte-first to an SPI serializer in DREQ-gated bursts.
module mp3_rom_streamer
    import mp3_pkg::*;
#(
    parameter int unsigned MUSIC_SIZE = 21698,
    parameter bit          LOOP       = 1'b1,
    parameter int unsigned BURST      = 32
) (
    input  logic        mp3_clk,
    input  logic        rst,
    input  logic        start,
    input  logic        DREQ,
    output logic [20:0] rom_addr,
    input  logic [31:0] rom_data,
    output logic [7:0]  byte_data,
    output logic        byte_valid,
    input  logic        byte_ready,
    output logic        busy,
    output logic        music_over
);

    // Extra headroom so a BURST that is not a word multiple cannot wrap mid-word.
    localparam int unsigned BURST_W   = $clog2(BURST + BYTES_PER_WORD);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MUSIC_SIZE - 1);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(BYTES_PER_WORD - 1);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [BURST_W-1:0]  burst_q, burst_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [WORD_W-1:0]   word_q, word_d;
    logic                mo_q, mo_d;
    logic                busy_q, busy_d;
    logic                valid_q, valid_d;
    logic [7:0]          data_q, data_d;

    logic dreq_s;
    logic xfer;
    logic word_end;
    logic track_end;
    logic burst_full;

    dreq_sync u_dreq_sync (
        .clk_i   (mp3_clk),
        .rst_i   (rst),
        .async_i (DREQ),
        .sync_o  (dreq_s)
    );

    assign xfer       = (state_q == SEND) && byte_ready;
    assign word_end   = xfer && (idx_q == LAST_IDX);
    assign track_end  = word_end && (addr_q == LAST_ADDR);
    assign burst_full = (32'(burst_q) + 32'd1) >= BURST;

    always_ff @(posedge mp3_clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            burst_q <= '0;
            idx_q   <= '0;
            word_q  <= '0;
            mo_q    <= 1'b0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            burst_q <= burst_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
            mo_q    <= mo_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    // Next state and datapath; a start pulse overrides whatever the FSM chose.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        burst_d = burst_q;
        idx_d   = idx_q;
        word_d  = word_q;
        mo_d    = track_end;

        case (state_q)
            IDLE: begin
            end
            WAIT_DREQ: begin
                if (dreq_s) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                state_d = LOAD;
            end
            LOAD: begin
                word_d  = rom_data;
                idx_d   = '0;
                state_d = SEND;
            end
            SEND: begin
                if (xfer) begin
                    idx_d   = idx_q + IDX_W'(1);
                    burst_d = burst_q + BURST_W'(1);
                    if (word_end) begin
                        addr_d = track_end ? ADDR_W'(0) : addr_q + ADDR_W'(1);
                        if (track_end && !LOOP) begin
                            state_d = DONE;
                        end else if (burst_full) begin
                            burst_d = '0;
                            state_d = WAIT_DREQ;
                        end else begin
                            state_d = FETCH;
                        end
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (start) begin
            addr_d  = '0;
            burst_d = '0;
            state_d = dreq_s ? FETCH : WAIT_DREQ;
        end
    end

    // Outputs are registered from the next state so they line up with state_q.
    always_comb begin
        busy_d  = 1'b0;
        valid_d = 1'b0;
        data_d  = 8'd0;
        if ((state_d != IDLE) && (state_d != DONE)) begin
            busy_d = 1'b1;
        end
        if (state_d == SEND) begin
            valid_d = 1'b1;
            data_d  = byte_sel(word_d, idx_d);
        end
    end

    assign rom_addr   = addr_q;
    assign byte_data  = data_q;
    assign byte_valid = valid_q;
    assign busy       = busy_q;
    assign music_over = mo_q;

endmodule

// File: tb/tb_mp3_rom_streamer.sv
// Scoreboard bench: three streamer instances (16-word loop, 3-word stop, 3-word loop), one active at a time.
module tb_mp3_rom_streamer;

    typedef struct {
        int         inst;
        logic [7:0] val;
        bit         last;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [2:0]  start;
    logic [2:0]  dreq;
    logic [2:0]  ready;
    logic [2:0]  bv;
    logic [2:0]  busy;
    logic [2:0]  mo;
    logic [7:0]  bd [3];
    logic [20:0] ra [3];
    logic [31:0] rd [3];

    exp_t        sb[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          mo_cnt [3];
    logic [2:0]  mo_pend;
    logic [2:0]  hold_pend;
    logic [7:0]  hold_val [3];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mp3_rom_streamer #(
            .MUSIC_SIZE (g == 0 ? 16 : 3),
            .LOOP       (g != 1),
            .BURST      (32)
        ) u_dut (
            .mp3_clk    (clk),
            .rst        (rst),
            .start      (start[g]),
            .DREQ       (dreq[g]),
            .rom_addr   (ra[g]),
            .rom_data   (rd[g]),
            .byte_data  (bd[g]),
            .byte_valid (bv[g]),
            .byte_ready (ready[g]),
            .busy       (busy[g]),
            .music_over (mo[g])
        );
    end

    function automatic logic [31:0] rom_word(input logic [20:0] a);
        logic [7:0] b;
        b = a[7:0];
        if (a == 21'd0) return 32'hAABBCCDD;
        return {b, b + 8'h10, b + 8'h20, b + 8'h30};
    endfunction

    // Synchronous ROM, one cycle of latency.
    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) rd[k] <= rom_word(ra[k]);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_bytes(input int k, input int first_word, input int nbytes, input int size);
        for (int n = 0; n < nbytes; n++) begin
            int          w;
            int          b;
            logic [31:0] word;
            exp_t        e;
            w      = (first_word + n / 4) % size;
            b      = n % 4;
            word   = rom_word(21'(w));
            e.inst = k;
            e.val  = word[31 - 8 * b -: 8];
            e.last = (w == size - 1) && (b == 3);
            sb.push_back(e);
        end
    endtask

    task automatic pulse_start(input int k);
        @(posedge clk); #1 start[k] = 1'b1;
        @(posedge clk); #1 start[k] = 1'b0;
    endtask

    // Drive ready until every queued byte has been taken, then park ready low.
    task automatic drain(input int k, input bit rnd, input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(posedge clk); #1;
            if (sb.size() == 0) ok = 1'b1;
            else ready[k] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        ready[k] = 1'b0;
        check($sformatf("drain%0d_left", k), 32'(sb.size()), 32'd0);
    endtask

    task automatic wait_valid(input int k, input int budget);
        bit got;
        got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk);
            got = (bv[k] === 1'b1);
        end
        check($sformatf("valid_seen%0d", k), 32'(got), 32'd1);
    endtask

    // Monitor: pops the scoreboard on every transfer, checks music_over timing and hold stability.
    initial begin
        exp_t e;
        mo_pend   = '0;
        hold_pend = '0;
        for (int k = 0; k < 3; k++) mo_cnt[k] = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                mo_pend   = '0;
                hold_pend = '0;
            end else begin
                for (int k = 0; k < 3; k++) begin
                    if (mo[k] === 1'b1) mo_cnt[k]++;
                    if (mo[k] === 1'b1 || mo_pend[k])
                        check($sformatf("music_over%0d", k), 32'(mo[k]), 32'(mo_pend[k]));
                    mo_pend[k] = 1'b0;
                    if (hold_pend[k] && bv[k] === 1'b1)
                        check($sformatf("hold%0d", k), 32'(bd[k]), 32'(hold_val[k]));
                    hold_pend[k] = (bv[k] === 1'b1) && !ready[k];
                    hold_val[k]  = bd[k];
                    if (bv[k] === 1'b1 && ready[k]) begin
                        if (sb.size() == 0) begin
                            n_vec++;
                            n_err++;
                            $display("FAIL extra_byte%0d: got %0h with none expected", k, bd[k]);
                        end else begin
                            e = sb.pop_front();
                            check($sformatf("byte%0d", k), 32'(bd[k]), 32'(e.val));
                            check($sformatf("byte_inst%0d", k), 32'(k), 32'(e.inst));
                            mo_pend[k] = e.last;
                        end
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;
        int   lat;
        bit   done;

        rst   = 1'b1;
        start = '0;
        dreq  = '0;
        ready = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("rst_valid%0d", k), 32'(bv[k]), 32'd0);
            check($sformatf("rst_busy%0d", k), 32'(busy[k]), 32'd0);
            check($sformatf("rst_mo%0d", k), 32'(mo[k]), 32'd0);
            check($sformatf("rst_data%0d", k), 32'(bd[k]), 32'd0);
            check($sformatf("rst_addr%0d", k), 32'(ra[k]), 32'd0);
        end
        @(posedge clk); #1 rst = 1'b0;

        // First burst: AA BB CC DD lead, DREQ dropped right after start.
        dreq[0] = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        push_bytes(0, 0, 32, 16);
        pulse_start(0);
        dreq[0] = 1'b0;
        drain(0, 1'b0, 400);
        ready[0] = 1'b1;
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            seen = seen | bv[0];
        end
        check("burst_gap_valid", 32'(seen), 32'd0);
        check("burst_gap_busy", 32'(busy[0]), 32'd1);

        // Second burst wraps at word 15, third runs to word 5 byte 1 under random ready.
        push_bytes(0, 8, 54, 16);
        @(posedge clk); #1 dreq[0] = 1'b1;
        lat = 0;
        for (int i = 1; i <= 5 && lat == 0; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (bv[0] === 1'b1) lat = i;
        end
        check("dreq_latency_le5", 32'(lat != 0), 32'd1);
        drain(0, 1'b1, 1000);
        @(negedge clk);
        check("pre_restart_byte", 32'(bd[0]), 32'h25);

        // Restart mid-word drops the rest of word 5.
        push_bytes(0, 0, 12, 16);
        pulse_start(0);
        drain(0, 1'b1, 600);
        wait_valid(0, 20);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst_valid", 32'(bv[0]), 32'd0);
        check("midrst_data", 32'(bd[0]), 32'd0);
        check("midrst_busy", 32'(busy[0]), 32'd0);
        check("midrst_mo", 32'(mo[0]), 32'd0);
        check("midrst_addr", 32'(ra[0]), 32'd0);
        @(posedge clk); #1 rst = 1'b0;

        // Start coinciding with a transfer: the byte counts, then playback restarts.
        repeat (4) @(posedge clk);
        #1;
        push_bytes(0, 0, 2, 16);
        ready[0] = 1'b1;
        pulse_start(0);
        done = 1'b0;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk); #1;
            if (sb.size() == 0) begin
                start[0] = 1'b1;
                push_bytes(0, 0, 4, 16);
                @(posedge clk); #1 start[0] = 1'b0;
                done = 1'b1;
            end
        end
        check("start_on_transfer", 32'(done), 32'd1);
        drain(0, 1'b0, 200);
        check("mo_count0", 32'(mo_cnt[0]), 32'd1);

        // Three-word track, LOOP=0.
        dreq[1] = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        push_bytes(1, 0, 12, 3);
        pulse_start(1);
        drain(1, 1'b0, 300);
        ready[1] = 1'b1;
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            seen = seen | bv[1];
        end
        check("stop_no_valid", 32'(seen), 32'd0);
        check("stop_busy", 32'(busy[1]), 32'd0);
        check("stop_mo_count", 32'(mo_cnt[1]), 32'd1);
        ready[1] = 1'b0;

        // Three-word track, LOOP=1: byte 13 is word 0 MSB again.
        dreq[2] = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        push_bytes(2, 0, 16, 3);
        pulse_start(2);
        drain(2, 1'b1, 600);
        @(negedge clk);
        check("loop_mo_count", 32'(mo_cnt[2]), 32'd1);
        check("loop_busy", 32'(busy[2]), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
